// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampling 8N1 UART receiver with a built-in oversample tick generator.
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   rx_sync     - synchronized serial line, idle high
//   rx_data     - last correctly received byte (first wire bit in bit 0)
//   rx_data_rdy - one-cycle strobe, rx_data valid on that cycle and held afterwards
//   frm_err     - one-cycle strobe, stop bit sampled low
//   busy        - high while a frame is in progress
module uart_rx_fsm #(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_sync,
   output logic [7:0] rx_data,
   output logic       rx_data_rdy,
   output logic       frm_err,
   output logic       busy
);

   localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = 3;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

   // Elaboration-time guard on the parameter set.
   if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0) || (DIV == 0)) begin : g_bad_params
      $error("uart_rx_fsm: OVERSAMPLE must be even and >= 8, and CLK_FREQ >= BAUD_RATE*OVERSAMPLE");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_e;

   state_e             state_q, state_d;
   logic               armed_q, armed_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
   logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic [7:0]         rx_data_q, rx_data_d;
   logic               rdy_q, rdy_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               tick_c;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         armed_q   <= 1'b0;
         div_cnt_q <= '0;
         os_cnt_q  <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         armed_q   <= armed_d;
         div_cnt_q <= div_cnt_d;
         os_cnt_q  <= os_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         rdy_q     <= rdy_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   // Oversample tick: only runs outside IDLE so the first tick lands DIV clocks after the start edge.
   assign tick_c = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);

   // Next-state, counters and output strobes.
   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q | rx_sync;
      div_cnt_d = '0;
      os_cnt_d  = os_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      rdy_d     = 1'b0;
      err_d     = 1'b0;

      if (state_q != S_IDLE) begin
         div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
      end

      if (tick_c) begin
         os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            os_cnt_d  = '0;
            bit_idx_d = '0;
            // A line held low since reset must not look like a start bit.
            if (armed_q && !rx_sync) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (tick_c && (os_cnt_q == OS_HALF)) begin
               if (!rx_sync) begin
                  state_d   = S_DATA;
                  os_cnt_d  = '0;
                  bit_idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_DATA: begin
            if (tick_c && (os_cnt_q == OS_LAST)) begin
               shift_d   = {rx_sync, shift_q[7:1]};
               bit_idx_d = bit_idx_q + BIT_W'(1);
               if (bit_idx_q == BIT_W'(7)) begin
                  state_d = S_STOP;
               end
            end
         end

         S_STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
            if (tick_c && (os_cnt_q == OS_LAST)) begin
               if (rx_sync) begin
                  rx_data_d = shift_q;
                  rdy_d     = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end
         end

         S_WAIT_HIGH: begin
            // A break reports once; wait for the line to recover before rearming.
            if (rx_sync) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_d = (state_d != S_IDLE);

   assign rx_data     = rx_data_q;
   assign rx_data_rdy = rdy_q;
   assign frm_err     = err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: scoreboard bench for uart_rx_fsm; a serial driver queues the expected
// byte / framing-error events, an independent monitor pops and compares them.
module tb_uart_rx_fsm;

   localparam int unsigned CLK_FREQ   = 7_372_800;
   localparam int unsigned BAUD_RATE  = 115_200;
   localparam int unsigned OVERSAMPLE = 16;
   localparam int DIV  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int BITP = DIV * OVERSAMPLE;
   localparam int LAT  = (OVERSAMPLE / 2 + 9 * OVERSAMPLE) * DIV;
   localparam int SLOW = BITP + (BITP * 3 + 50) / 100;
   localparam int FAST = BITP - (BITP * 3 + 50) / 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_sync;
   logic [7:0] rx_data;
   logic       rx_data_rdy;
   logic       frm_err;
   logic       busy;

   uart_rx_fsm #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .OVERSAMPLE(OVERSAMPLE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_sync    (rx_sync),
      .rx_data    (rx_data),
      .rx_data_rdy(rx_data_rdy),
      .frm_err    (frm_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         start_cyc;
      bit         chk_lat;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] last_good = 8'h00;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the next queued event.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_data_rdy && frm_err) check("exclusive_strobes", 1, 0);
         if (rx_data_rdy || frm_err) begin
            if (q.size() == 0) begin
               check(rx_data_rdy ? "unexpected_rdy" : "unexpected_frm_err", 1, 0);
            end else begin
               mon_e = q.pop_front();
               check("event_kind_is_err", int'(frm_err), int'(mon_e.is_err));
               if (!mon_e.is_err) begin
                  check("rx_data", int'(rx_data), int'(mon_e.data));
                  last_good = mon_e.data;
                  if (mon_e.chk_lat) begin
                     n_checks++;
                     if ((cyc - mon_e.start_cyc < LAT - 2) || (cyc - mon_e.start_cyc > LAT + 2)) begin
                        n_errors++;
                        $display("FAIL latency: got %0d expected %0d+/-2", cyc - mon_e.start_cyc, LAT);
                     end
                  end
               end else begin
                  check("rx_data_held_on_err", int'(rx_data), int'(last_good));
               end
            end
         end
      end
   end

   // Drive one 8N1 frame LSB first; called and returns at a falling edge.
   task automatic send_frame(input logic [7:0] b, input int per, input bit stop_ok,
                             input bit chk_busy, input bit chk_lat);
      logic [9:0] bits;
      exp_t       e;
      bits        = {stop_ok, b, 1'b0};
      e.is_err    = !stop_ok;
      e.data      = b;
      e.start_cyc = cyc;
      e.chk_lat   = chk_lat;
      q.push_back(e);
      for (int i = 0; i < 10; i++) begin
         rx_sync = bits[i];
         for (int k = 0; k < per; k++) begin
            @(negedge clk);
            if (chk_busy && (i < 9) && (k == per / 2)) check("busy_in_frame", int'(busy), 1);
         end
      end
   endtask

   task automatic line_high(input int n);
      rx_sync = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [9:0] c3_bits;
      rst     = 1'b1;
      rx_sync = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rx_data", int'(rx_data), 0);
      check("reset_rdy", int'(rx_data_rdy), 0);
      check("reset_frm_err", int'(frm_err), 0);
      check("reset_busy", int'(busy), 0);
      rst = 1'b0;
      line_high(BITP);

      // Single frame with latency and busy coverage.
      send_frame(8'h55, BITP, 1'b1, 1'b1, 1'b1);
      line_high(4);
      check("busy_after_frame", int'(busy), 0);
      line_high(BITP);

      // Back-to-back frames, no idle gap.
      send_frame(8'hA5, BITP, 1'b1, 1'b0, 1'b0);
      send_frame(8'h00, BITP, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, BITP, 1'b1, 1'b0, 1'b0);
      line_high(2 * BITP);

      // Stop bit low followed by a long break.
      send_frame(8'h3C, BITP, 1'b0, 1'b0, 1'b0);
      rx_sync = 1'b0;
      repeat (20 * BITP) @(negedge clk);
      check("busy_during_break", int'(busy), 1);
      line_high(4);
      check("busy_after_break", int'(busy), 0);
      line_high(BITP);
      send_frame(8'h12, BITP, 1'b1, 1'b0, 1'b0);
      line_high(2 * BITP);

      // Start-bit glitch shorter than half a bit.
      rx_sync = 1'b0;
      repeat (5 * DIV) @(negedge clk);
      rx_sync = 1'b1;
      repeat (2) @(negedge clk);
      check("busy_glitch_start", int'(busy), 1);
      repeat (12 * DIV) @(negedge clk);
      check("busy_glitch_reject", int'(busy), 0);
      line_high(BITP);

      // Reset in the middle of bit 4 of 0xC3, line low at release.
      c3_bits = {1'b1, 8'hC3, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx_sync = c3_bits[i];
         repeat (BITP) @(negedge clk);
      end
      rx_sync = c3_bits[5];
      repeat (BITP / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      last_good = 8'h00;
      check("midrst_rx_data", int'(rx_data), 0);
      check("midrst_rdy", int'(rx_data_rdy), 0);
      check("midrst_frm_err", int'(frm_err), 0);
      check("midrst_busy", int'(busy), 0);
      repeat (3 * BITP) @(negedge clk);
      check("unarmed_no_start", int'(busy), 0);
      line_high(BITP);
      send_frame(8'h7E, BITP, 1'b1, 1'b0, 1'b0);
      line_high(BITP);

      // Baud skew in both directions.
      send_frame(8'h96, SLOW, 1'b1, 1'b0, 1'b0);
      line_high(BITP);
      send_frame(8'h69, FAST, 1'b1, 1'b0, 1'b0);
      line_high(BITP);

      // Randomized traffic with occasional framing errors.
      for (int n = 0; n < 30; n++) begin
         logic [7:0] b;
         int         per;
         bit         ok;
         b   = 8'($urandom_range(0, 255));
         per = int'($urandom_range(FAST, SLOW));
         ok  = ($urandom_range(0, 7) != 0);
         send_frame(b, per, ok, 1'b0, 1'b0);
         if (!ok) begin
            rx_sync = 1'b0;
            repeat (int'($urandom_range(0, 3 * BITP))) @(negedge clk);
            line_high(BITP);
         end else begin
            line_high(int'($urandom_range(0, 2 * BITP)));
         end
      end

      // Drain outstanding expectations with a bounded wait.
      for (int t = 0; (t < 4 * BITP) && (q.size() > 0); t++) @(negedge clk);
      check("scoreboard_drained", q.size(), 0);
      line_high(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Oversampling UART receiver for the 8N1 serial line.
- Consumes the already-synchronized RX line from the two-flop metastability hardener and produces parallel bytes with a one-cycle ready strobe.
- Sits between the RX pin synchronizer and the downstream byte consumer (command decoder / loopback FIFO).
- Contains its own oversample tick generator; no external baud enable.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, serial bit rate in bits/s
- OVERSAMPLE, 16, ticks per bit period; must be even and >= 8
- DIV (localparam), CLK_FREQ/(BAUD_RATE*OVERSAMPLE) truncated (54 at defaults), clocks per oversample tick

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_sync  input  1  synchronized serial line; idle high
- rx_data  output  8  last correctly received byte, LSB first on the wire
- rx_data_rdy  output  1  one-cycle pulse; rx_data valid on that cycle and held afterwards
- frm_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset (synchronous, active-high):
  - Values on the cycle after rst is sampled high: rx_data=8'h00, rx_data_rdy=0, frm_err=0, busy=0, state=IDLE, armed=0, all counters 0.
  - A reset asserted mid-frame abandons the frame; no strobe is emitted.
- Arming: after reset, IDLE ignores rx_sync until it has been sampled high at least once (armed=1). A line held low through reset release must not start a frame.
- Tick generator:
  - Counter runs 0..DIV-1; a tick fires on the cycle the counter equals DIV-1.
  - Counter is held at 0 in IDLE and is cleared on the IDLE->START transition.
  - os_cnt counts ticks 0..OVERSAMPLE-1 and wraps.
- IDLE:
  - Transition: armed and rx_sync=0 -> START. Clear the tick counter and os_cnt; busy rises on the next cycle.
- START:
  - Action: on the tick where os_cnt=OVERSAMPLE/2-1 (mid start bit), sample rx_sync.
  - Transition: sample=0 -> DATA, with os_cnt reset to 0 and bit_idx=0.
  - Transition: sample=1 -> IDLE (glitch reject). No strobe.
- DATA:
  - Action: on each tick where os_cnt=OVERSAMPLE-1 (one bit period after the previous sample, i.e. mid-bit), shift rx_sync into shift_reg MSB, shifting right, so the first received bit ends in bit 0.
  - Action: bit_idx increments after each sample.
  - Transition: after the 8th sample -> STOP.
- STOP:
  - Action: on the tick where os_cnt=OVERSAMPLE-1, sample rx_sync.
  - Transition: sample=1 -> rx_data<=shift_reg; rx_data_rdy=1 for exactly one cycle (the cycle after the sample tick); go to IDLE.
  - Transition: sample=0 -> frm_err=1 for exactly one cycle; rx_data unchanged; go to WAIT_HIGH.
- WAIT_HIGH:
  - Transition: remain until rx_sync=1, then -> IDLE. A break condition (line held low) yields exactly one frm_err, not repeated errors.
- Early return: IDLE is re-entered at mid stop bit, so a start bit immediately following the stop bit (back-to-back frames) is detected without loss.
- Exclusivity: rx_data_rdy and frm_err are never high on the same cycle.
- Latency: from the first cycle rx_sync is low in IDLE to the rx_data_rdy pulse is (OVERSAMPLE/2 + 9*OVERSAMPLE)*DIV clocks +/-2. At defaults: 152*54 = 8208 clocks.
- Jitter tolerance: sampling at mid-bit tolerates cumulative baud mismatch below +/-(OVERSAMPLE/2-1)/OVERSAMPLE bit period over 9.5 bits.

Test Plan:
- Reset, then drive an 8N1 frame of 0x55 at 864 clocks/bit (defaults) -> rx_data=8'h55; a single one-cycle rx_data_rdy pulse 8208+/-2 clocks after the start edge; frm_err stays 0; busy high for the whole frame, low after.
- Back-to-back frames 0xA5, 0x00, 0xFF with no idle gap between stop and next start -> three rdy pulses with rx_data 8'hA5, 8'h00, 8'hFF in order; no frm_err.
- Frame 0x3C with stop bit driven low, then line held low for 20 bit periods, then high -> exactly one frm_err pulse; rx_data keeps its previous value; receiver returns to IDLE only after the line goes high; next 0x12 frame received correctly.
- Glitch: rx_sync low for 5 oversample ticks (270 clocks), then high -> no rdy, no frm_err; busy returns to 0 after the mid-start sample.
- Assert rst for 1 cycle in the middle of bit 4 of a 0xC3 frame, with the line low at reset release -> all outputs 0 the next cycle; no frame starts until the line has been seen high; a subsequent 0x7E frame is received correctly.
- Baud skew: transmitter runs 3% slow (890 clocks/bit) sending 0x96, then 3% fast (838 clocks/bit) sending 0x69 -> both bytes received correctly, no frm_err.
